serial_to_parallel_rx: RTL and testbench
========================================

Name: serial_to_parallel_rx

Overview:
- Downstream receiver for the parallel-to-serial stage.
- Watches the same load strobe and serial bit stream that the serializer drives, and rebuilds each 8-bit item, LSB first.
- Queues completed bytes in a small FIFO and presents them on a valid/ready output port.
- Flags protocol violations (truncated frames, overflow) so the bench can compare reconstructed bytes against the loaded values.

Parameters:
- DEPTH, 4, output FIFO entries (power of 2, ≥2).
- CNT_W, 16, width of completed-frame counter.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous, active-high reset.
- load  in  1  frame start strobe, same cycle the serializer captures parallel_in.
- serial_in  in  1  serializer output; bit 0 valid the cycle after load, bit 7 seven cycles later.
- out_data  out  8  head-of-FIFO byte.
- out_valid  out  1  FIFO non-empty.
- out_ready  in  1  consumer accepts head when out_valid&&out_ready.
- busy  out  1  frame in progress (state SHIFT).
- frame_err  out  1  one-cycle pulse: frame aborted by early load.
- overflow  out  1  sticky: byte dropped because FIFO full; cleared only by rst.
- frame_cnt  out  CNT_W  bytes successfully pushed, wraps at 2^CNT_W.

Behaviour:
- Reset (rst=1 at posedge):
  - state=IDLE, bit_cnt=0, shift reg=0, FIFO empty.
  - out_valid=0, out_data=0, busy=0, frame_err=0, overflow=0, frame_cnt=0.
  - rst overrides all other inputs, including a frame in flight; the partial byte is discarded.
- FSM states: IDLE, SHIFT.
- IDLE:
  - load=1 → SHIFT, bit_cnt=0. The serial_in value in the load cycle is ignored.
  - load=0 → stay in IDLE.
- SHIFT, load=0:
  - Capture serial_in into shift[bit_cnt], then increment bit_cnt.
  - When bit_cnt==7: byte complete → push {serial_in, shift[6:0]} into the FIFO, return to IDLE.
- SHIFT, load=1, bit_cnt<7:
  - Abort the partial byte (no push) and pulse frame_err the next cycle.
  - Restart: stay in SHIFT with bit_cnt=0. This cycle counts as the new load cycle.
- SHIFT, load=1, bit_cnt==7 (back-to-back frames):
  - Bit 7 is captured and the byte is pushed normally; no error.
  - Next state is SHIFT with bit_cnt=0.
- Timing: latency from the bit-7 cycle to out_valid is 1 cycle (registered FIFO write; data visible the following cycle).
- FIFO: first-word fall-through; out_data = mem[rd_ptr].
  - Pop on out_valid&&out_ready.
  - Push and pop in the same cycle: both happen, occupancy unchanged, including when full.
  - Push when full and no pop: byte dropped, overflow set, frame_cnt not incremented.
  - Pop when empty: ignored.
  - Pointers are log2(DEPTH) bits plus a wrap bit; full/empty are derived from these.
- frame_cnt: increments once per successful push; wraps modulo 2^CNT_W with no flag.
- busy = (state==SHIFT).
- out_data and out_valid are stable while out_valid=1 and out_ready=0.

Test Plan:
1. Single frame:
   - Stimulus: rst 2 cycles, then load=1, then serial bits 1,0,1,0,0,1,0,1, out_ready=1.
   - Response: out_valid=1 exactly 1 cycle after the bit-7 cycle, out_data=0xA5, frame_cnt=1, busy high for 8 cycles.
2. Back-to-back frames:
   - Stimulus: load=1 in the bit-7 cycle of 0x3C; next frame 0xFF.
   - Response: out_data 0x3C then 0xFF, frame_err never pulses, frame_cnt=2.
3. Early load:
   - Stimulus: load, 4 bits, load again, then 8 bits of 0x81.
   - Response: frame_err pulses once; the only byte output is 0x81; frame_cnt=1.
4. Backpressure and overflow (DEPTH=4):
   - Stimulus: out_ready=0; send 5 frames 0x01..0x05.
   - Response: FIFO holds 0x01..0x04, overflow=1 after the 5th frame, frame_cnt=4. Raising out_ready drains 0x01,0x02,0x03,0x04 in order, with out_data stable while stalled.
5. Push and pop together when full:
   - Stimulus: with the FIFO full, assert out_ready=1 in the cycle the next byte 0x55 is pushed.
   - Response: no overflow; 0x55 emerges last.
6. Reset mid-frame:
   - Stimulus: rst asserted after 3 bits of a frame.
   - Response: no byte pushed, busy=0 and all outputs zero the next cycle; a following 0x5A frame is received correctly.

Source files
------------

// File: rtl/serial_to_parallel_rx.sv
// serial_to_parallel_rx: rebuilds LSB-first 8-bit frames from a load strobe
// and a serial bit stream, and queues the completed bytes in a small
// first-word-fall-through FIFO behind a valid/ready port. Early loads abort
// the partial byte (frame_err); pushes into a full FIFO are dropped (overflow).
module serial_to_parallel_rx #(
    parameter int DEPTH = 4,   // output FIFO entries, power of 2, >= 2
    parameter int CNT_W = 16   // completed-frame counter width
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             serial_in,
    output logic [7:0]       out_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             busy,
    output logic             frame_err,
    output logic             overflow,
    output logic [CNT_W-1:0] frame_cnt
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int PW    = PTR_W + 1;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t         state, next_state;
    logic [2:0]     bit_cnt, next_bit_cnt;
    logic [6:0]     shift_reg;
    logic           capture;   // store serial_in into shift_reg[bit_cnt]
    logic           push;      // bit 7 arrives this cycle: byte complete
    logic           abort;     // load arrived before bit 7: drop partial byte
    logic [7:0]     push_data;

    logic [7:0]     mem [DEPTH];
    logic [PW-1:0]  wr_ptr, rd_ptr;
    logic           fifo_empty, fifo_full;
    logic           pop, do_write;

    // State register and bit counter.
    // NOTE: sequential state uses non-blocking (<=) so every flop samples the
    // pre-edge values regardless of the order blocks are evaluated in.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            bit_cnt <= 3'd0;
        end else begin
            state   <= next_state;
            bit_cnt <= next_bit_cnt;
        end
    end

    // Next-state logic: frame start, bit capture, completion and early-load restart.
    // NOTE: every signal is given a default first, so no path leaves one
    // unassigned and no latch is inferred.
    always_comb begin
        next_state   = state;
        next_bit_cnt = bit_cnt;
        capture      = 1'b0;
        push         = 1'b0;
        abort        = 1'b0;
        case (state)
            IDLE: begin
                if (load) begin
                    next_state   = SHIFT;
                    next_bit_cnt = 3'd0;
                end
            end
            SHIFT: begin
                if (bit_cnt == 3'd7) begin
                    // Last bit: byte is pushed even if a new load overlaps it.
                    push         = 1'b1;
                    next_bit_cnt = 3'd0;
                    next_state   = load ? SHIFT : IDLE;
                end else if (load) begin
                    // Early load restarts the frame; this cycle is the new load cycle.
                    abort        = 1'b1;
                    next_bit_cnt = 3'd0;
                end else begin
                    capture      = 1'b1;
                    next_bit_cnt = bit_cnt + 3'd1;
                end
            end
            default: begin
                next_state   = IDLE;
                next_bit_cnt = 3'd0;
            end
        endcase
    end

    // Shift register holding bits 0..6 of the frame in progress.
    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= 7'd0;
        end else if (capture) begin
            shift_reg[bit_cnt] <= serial_in;
        end
    end

    assign push_data = {serial_in, shift_reg};

    // FIFO status; pointers carry an extra wrap bit to tell full from empty.
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[PTR_W] != rd_ptr[PTR_W]) &&
                        (wr_ptr[PTR_W-1:0] == rd_ptr[PTR_W-1:0]);
    assign pop        = !fifo_empty && out_ready;
    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign do_write   = push && (!fifo_full || pop);

    // FIFO storage write.
    // NOTE: the data array has no reset; the pointers alone define which
    // entries are valid, and out_data is forced to zero while empty.
    always_ff @(posedge clk) begin
        if (!rst && do_write) begin
            mem[wr_ptr[PTR_W-1:0]] <= push_data;
        end
    end

    // FIFO read/write pointers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (do_write) wr_ptr <= wr_ptr + PW'(1);
            if (pop)      rd_ptr <= rd_ptr + PW'(1);
        end
    end

    // Sticky overflow: a completed byte was dropped because the FIFO was full.
    always_ff @(posedge clk) begin
        if (rst) begin
            overflow <= 1'b0;
        end else if (push && fifo_full && !pop) begin
            overflow <= 1'b1;
        end
    end

    // Count of bytes actually stored; wraps silently.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_cnt <= '0;
        end else if (do_write) begin
            frame_cnt <= frame_cnt + CNT_W'(1);
        end
    end

    // One-cycle error pulse following an aborted frame.
    always_ff @(posedge clk) begin
        if (rst) begin
            frame_err <= 1'b0;
        end else begin
            frame_err <= abort;
        end
    end

    assign busy      = (state == SHIFT);
    assign out_valid = !fifo_empty;
    assign out_data  = fifo_empty ? 8'h00 : mem[rd_ptr[PTR_W-1:0]];

endmodule

// File: tb/tb_serial_to_parallel_rx.sv
// Self-checking bench for serial_to_parallel_rx: a frame-level model (bit
// position + byte accumulator + byte queue) is compared against the DUT every
// cycle, and directed scenarios pin expected bytes and counts with literals.
module tb_serial_to_parallel_rx;

    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic             load = 1'b0;
    logic             serial_in = 1'b0;
    logic             out_ready = 1'b0;
    logic [7:0]       out_data;
    logic             out_valid;
    logic             busy;
    logic             frame_err;
    logic             overflow;
    logic [CNT_W-1:0] frame_cnt;

    always #5 clk = ~clk;

    serial_to_parallel_rx #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .serial_in (serial_in),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .busy      (busy),
        .frame_err (frame_err),
        .overflow  (overflow),
        .frame_cnt (frame_cnt)
    );

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- behavioural model ----------------
    // m_pos: -1 when no frame is open, else number of data bits received.
    int               m_pos = -1;
    logic [7:0]       m_acc = 8'h00;
    logic [7:0]       m_q[$];
    bit               m_err = 1'b0;
    bit               m_ovf = 1'b0;
    logic [CNT_W-1:0] m_cnt = '0;
    bit               chk_en = 1'b0;

    // Observations of the DUT used by the directed checks.
    logic [7:0]       got[$];
    int               busy_cycles = 0;
    int               err_pulses  = 0;

    always @(posedge clk) begin
        bit         do_pop;
        bit         do_push;
        bit         err;
        logic [7:0] byte_v;
        int         occ;
        // DUT observation with pre-edge values.
        if (!rst) begin
            if (out_valid && out_ready) got.push_back(out_data);
            if (busy) busy_cycles++;
            if (frame_err) err_pulses++;
        end
        // Model update.
        if (rst) begin
            m_pos = -1; m_acc = 8'h00; m_q.delete();
            m_err = 1'b0; m_ovf = 1'b0; m_cnt = '0;
        end else begin
            occ     = m_q.size();
            do_pop  = (occ > 0) && out_ready;
            do_push = 1'b0;
            err     = 1'b0;
            byte_v  = 8'h00;
            if (m_pos == 7) begin
                byte_v  = m_acc | (8'(serial_in) << 7);
                do_push = 1'b1;
                m_pos   = load ? 0 : -1;
                m_acc   = 8'h00;
            end else if (m_pos >= 0) begin
                if (load) begin
                    err   = 1'b1;
                    m_pos = 0;
                    m_acc = 8'h00;
                end else begin
                    m_acc = m_acc | (8'(serial_in) << m_pos);
                    m_pos++;
                end
            end else if (load) begin
                m_pos = 0;
                m_acc = 8'h00;
            end
            if (do_pop) void'(m_q.pop_front());
            if (do_push) begin
                if (occ == DEPTH && !do_pop) m_ovf = 1'b1;
                else begin
                    m_q.push_back(byte_v);
                    m_cnt = m_cnt + 1'b1;
                end
            end
            m_err = err;
        end
    end

    // Per-cycle comparison against the model, away from the active edge.
    always @(negedge clk) begin
        if (chk_en) begin
            check("out_valid", out_valid, (m_q.size() > 0));
            check("out_data",  out_data,  (m_q.size() > 0) ? m_q[0] : 8'h00);
            check("busy",      busy,      (m_pos >= 0));
            check("frame_err", frame_err, m_err);
            check("overflow",  overflow,  m_ovf);
            check("frame_cnt", frame_cnt, m_cnt);
        end
    end

    // ---------------- stimulus helpers ----------------
    task automatic clear_obs();
        got.delete();
        busy_cycles = 0;
        err_pulses  = 0;
    endtask

    task automatic do_reset();
        rst = 1'b1; load = 1'b0; serial_in = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        clear_obs();
        chk_en = 1'b1;
    endtask

    // Eight data bits, LSB first; optional load and/or out_ready in the bit-7 cycle.
    task automatic send_bits(input logic [7:0] b, input bit ld_last, input bit rdy_last);
        for (int i = 0; i < 8; i++) begin
            load      = (i == 7) ? ld_last : 1'b0;
            serial_in = b[i];
            if (i == 7 && rdy_last) out_ready = 1'b1;
            @(negedge clk);
        end
        load      = 1'b0;
        serial_in = 1'b0;
        if (rdy_last) out_ready = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] b, input bit rdy_last);
        load      = 1'b1;
        serial_in = 1'b1;   // ignored in the load cycle
        @(negedge clk);
        send_bits(b, 1'b0, rdy_last);
    endtask

    // ---------------- directed tests ----------------
    initial begin
        @(negedge clk);

        // 1. Single frame 0xA5 (bits 1,0,1,0,0,1,0,1), consumer always ready.
        out_ready = 1'b1;
        do_reset();
        check("rst_valid", out_valid, 1'b0);
        check("rst_busy",  busy, 1'b0);
        check("rst_cnt",   frame_cnt, 16'd0);
        check("rst_data",  out_data, 8'h00);
        send_frame(8'hA5, 1'b0);
        check("t1_valid_after_bit7", out_valid, 1'b1);
        check("t1_data", out_data, 8'hA5);
        check("t1_cnt", frame_cnt, 16'd1);
        check("t1_busy_cycles", busy_cycles, 8);
        repeat (2) @(negedge clk);
        check("t1_n_out", got.size(), 1);
        check("t1_byte", got[0], 8'hA5);

        // 2. Back-to-back frames: load overlaps bit 7 of 0x3C.
        do_reset();
        load = 1'b1; @(negedge clk);
        send_bits(8'h3C, 1'b1, 1'b0);
        send_bits(8'hFF, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        check("t2_n_out", got.size(), 2);
        check("t2_byte0", got[0], 8'h3C);
        check("t2_byte1", got[1], 8'hFF);
        check("t2_no_err", err_pulses, 0);
        check("t2_cnt", frame_cnt, 16'd2);

        // 3. Early load after 4 bits, then a full 0x81 frame.
        do_reset();
        load = 1'b1; @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 4; i++) begin
            serial_in = 1'b1;
            @(negedge clk);
        end
        send_frame(8'h81, 1'b0);
        repeat (3) @(negedge clk);
        check("t3_err_pulses", err_pulses, 1);
        check("t3_n_out", got.size(), 1);
        check("t3_byte", got[0], 8'h81);
        check("t3_cnt", frame_cnt, 16'd1);

        // 4. Backpressure: five frames into a four-entry FIFO.
        out_ready = 1'b0;
        do_reset();
        for (int i = 1; i <= 5; i++) send_frame(8'(i), 1'b0);
        check("t4_overflow", overflow, 1'b1);
        check("t4_cnt", frame_cnt, 16'd4);
        check("t4_head", out_data, 8'h01);
        repeat (4) @(negedge clk);   // stalled: model checks stability
        check("t4_head_stalled", out_data, 8'h01);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("t4_n_out", got.size(), 4);
        for (int i = 0; i < 4; i++) check($sformatf("t4_byte%0d", i), got[i], 32'(i + 1));
        check("t4_empty", out_valid, 1'b0);
        check("t4_ovf_sticky", overflow, 1'b1);

        // 5. Full FIFO, pop coincides with the push of 0x55.
        out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) send_frame(8'h11 + 8'(i), 1'b0);
        send_frame(8'h55, 1'b1);
        check("t5_no_overflow", overflow, 1'b0);
        check("t5_cnt", frame_cnt, 16'd5);
        out_ready = 1'b1;
        repeat (6) @(negedge clk);
        check("t5_n_out", got.size(), 5);
        check("t5_first", got[0], 8'h11);
        check("t5_last", got[4], 8'h55);

        // 6. Reset three bits into a frame, then a clean 0x5A frame.
        clear_obs();
        load = 1'b1; @(negedge clk);
        load = 1'b0;
        for (int i = 0; i < 3; i++) begin
            serial_in = 1'b1;
            @(negedge clk);
        end
        rst = 1'b1; @(negedge clk);
        rst = 1'b0;
        check("t6_busy", busy, 1'b0);
        check("t6_valid", out_valid, 1'b0);
        check("t6_data", out_data, 8'h00);
        check("t6_cnt", frame_cnt, 16'd0);
        check("t6_err", frame_err, 1'b0);
        check("t6_ovf", overflow, 1'b0);
        send_frame(8'h5A, 1'b0);
        repeat (2) @(negedge clk);
        check("t6_n_out", got.size(), 1);
        check("t6_byte", got[0], 8'h5A);
        check("t6_cnt_after", frame_cnt, 16'd1);

        chk_en = 1'b0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
